// File: rtl/dmi_jtag_dr.sv
// dmi_jtag_dr: DMI access data register and request/response sequencer (TCK domain).
// Selected by the TAP when IR=DMIACCESS. It shifts the {addr, data, op} DR in and out.
// Each Update-DR issues at most one DMI request, and the module then collects the response.
// A sticky error is reported back to the TAP for dtmcs.dmistat.
//
// Ports:
//   tck_i, trst_ni             clock and asynchronous active-low reset
//   dmi_access_i               IR selects DMIACCESS; gates all DR actions
//   capture/shift/update_dr_i  TAP DR state indications
//   test_logic_reset_i         TAP in Test-Logic-Reset; clears DR and sticky error
//   dmi_reset_i                dtmcs.dmireset pulse; clears sticky error
//   tdi_i / tdo_o              serial data in / out (tdo_o = dr_q[0])
//   dmi_error_o                sticky error: 0 none, 2 op failed, 3 busy
//   dmi_req_*                  request channel (valid/ready, addr, op, data)
//   dmi_resp_*                 response channel (valid/ready, data, status)
module dmi_jtag_dr #(
    parameter int unsigned AbitsWidth = 7,
    parameter int unsigned DataWidth  = 32
) (
    input  logic                  tck_i,
    input  logic                  trst_ni,
    input  logic                  dmi_access_i,
    input  logic                  capture_dr_i,
    input  logic                  shift_dr_i,
    input  logic                  update_dr_i,
    input  logic                  test_logic_reset_i,
    input  logic                  dmi_reset_i,
    input  logic                  tdi_i,
    output logic                  tdo_o,
    output logic [1:0]            dmi_error_o,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output logic [AbitsWidth-1:0] dmi_req_addr_o,
    output logic [1:0]            dmi_req_op_o,
    output logic [DataWidth-1:0]  dmi_req_data_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  logic [DataWidth-1:0]  dmi_resp_data_i,
    input  logic [1:0]            dmi_resp_i
);

    localparam int unsigned DrWidth = AbitsWidth + DataWidth + 2;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWaitRead,
        StWrite,
        StWaitWrite
    } state_e;

    state_e                  state_q, state_d;
    logic [DrWidth-1:0]      dr_q, dr_d;
    logic [AbitsWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]    data_q, data_d;
    logic [1:0]              op_q, op_d;
    logic [1:0]              error_q, error_d;

    logic                    capture, shift, update;
    logic                    idle;
    logic [1:0]              dr_op;
    logic [DataWidth-1:0]    dr_data;
    logic [AbitsWidth-1:0]   dr_addr;
    logic                    dr_op_req;
    logic                    req_fire;
    logic                    busy_evt;
    logic                    resp_fire;
    logic                    fail_evt;

    assign capture   = dmi_access_i & capture_dr_i;
    assign shift     = dmi_access_i & shift_dr_i;
    assign update    = dmi_access_i & update_dr_i;
    assign idle      = (state_q == StIdle);

    assign dr_op     = dr_q[1:0];
    assign dr_data   = dr_q[DataWidth+1:2];
    assign dr_addr   = dr_q[DrWidth-1:DataWidth+2];
    assign dr_op_req = (dr_op == 2'd1) || (dr_op == 2'd2);

    // A pending sticky error blocks every Update-DR, including the busy report.
    assign req_fire  = update && (error_q == 2'd0) && dr_op_req && idle;
    assign busy_evt  = (capture && !idle) ||
                       (update && (error_q == 2'd0) && dr_op_req && !idle);
    assign resp_fire = dmi_resp_valid_i && dmi_resp_ready_o;
    assign fail_evt  = resp_fire && (dmi_resp_i != 2'd0);

    // ---------------- data register ----------------
    always_comb begin
        dr_d = dr_q;
        if (test_logic_reset_i) begin
            dr_d = '0;
        end else if (capture) begin
            dr_d = {addr_q, data_q, (idle ? error_q : 2'd3)};
        end else if (shift) begin
            dr_d = {tdi_i, dr_q[DrWidth-1:1]};
        end
    end

    // ---------------- sticky error ----------------
    // First error wins; dmireset overrides any event in the same cycle.
    always_comb begin
        error_d = error_q;
        if (dmi_reset_i || test_logic_reset_i) begin
            error_d = 2'd0;
        end else if (error_q == 2'd0) begin
            if (busy_evt) begin
                error_d = 2'd3;
            end else if (fail_evt) begin
                error_d = 2'd2;
            end
        end
    end

    // ---------------- request fields ----------------
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        op_d   = op_q;
        if (req_fire) begin
            addr_d = dr_addr;
            data_d = dr_data;
            op_d   = dr_op;
        end else if (resp_fire && (state_q == StWaitRead) && (dmi_resp_i == 2'd0)) begin
            data_d = dmi_resp_data_i;
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            dr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= '0;
            error_q <= '0;
        end else begin
            dr_q    <= dr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            error_q <= error_d;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // Test-Logic-Reset does not touch the FSM, so an issued request always completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    state_d = (dr_op == 2'd1) ? StRead : StWrite;
                end
            end
            StRead: begin
                if (dmi_req_ready_i) state_d = StWaitRead;
            end
            StWrite: begin
                if (dmi_req_ready_i) state_d = StWaitWrite;
            end
            StWaitRead, StWaitWrite: begin
                if (dmi_resp_valid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
        unique case (state_q)
            StRead, StWrite:         dmi_req_valid_o  = 1'b1;
            StWaitRead, StWaitWrite: dmi_resp_ready_o = 1'b1;
            default: ;
        endcase
    end

    // Fields only change on an Update-DR in Idle, so they hold while a request waits.
    assign dmi_req_addr_o = addr_q;
    assign dmi_req_op_o   = op_q;
    assign dmi_req_data_o = data_q;
    assign dmi_error_o    = error_q;
    assign tdo_o          = dr_q[0];

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Randomised scoreboard bench for dmi_jtag_dr.
// The main thread drives only the TAP pins. The model process runs on each falling edge.
// That process acts as the debug module, predicts the effect of the next rising edge,
// and checks requests and scanned-out DR values as they appear.
module tb_dmi_jtag_dr;

    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int DRW = AW + DW + 2;

    logic           tck = 1'b0;
    logic           trst_n = 1'b1;
    logic           dmi_access = 1'b0;
    logic           capture_dr = 1'b0;
    logic           shift_dr = 1'b0;
    logic           update_dr = 1'b0;
    logic           tlr = 1'b0;
    logic           dmi_reset = 1'b0;
    logic           tdi = 1'b0;
    logic           tdo;
    logic [1:0]     dmi_error;
    logic           dmi_req_valid;
    logic           dmi_req_ready = 1'b0;
    logic [AW-1:0]  dmi_req_addr;
    logic [1:0]     dmi_req_op;
    logic [DW-1:0]  dmi_req_data;
    logic           dmi_resp_valid = 1'b0;
    logic           dmi_resp_ready;
    logic [DW-1:0]  dmi_resp_data = '0;
    logic [1:0]     dmi_resp = 2'd0;

    dmi_jtag_dr #(.AbitsWidth(AW), .DataWidth(DW)) dut (
        .tck_i             (tck),
        .trst_ni           (trst_n),
        .dmi_access_i      (dmi_access),
        .capture_dr_i      (capture_dr),
        .shift_dr_i        (shift_dr),
        .update_dr_i       (update_dr),
        .test_logic_reset_i(tlr),
        .dmi_reset_i       (dmi_reset),
        .tdi_i             (tdi),
        .tdo_o             (tdo),
        .dmi_error_o       (dmi_error),
        .dmi_req_valid_o   (dmi_req_valid),
        .dmi_req_ready_i   (dmi_req_ready),
        .dmi_req_addr_o    (dmi_req_addr),
        .dmi_req_op_o      (dmi_req_op),
        .dmi_req_data_o    (dmi_req_data),
        .dmi_resp_valid_i  (dmi_resp_valid),
        .dmi_resp_ready_o  (dmi_resp_ready),
        .dmi_resp_data_i   (dmi_resp_data),
        .dmi_resp_i        (dmi_resp)
    );

    always #5 tck = ~tck;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    op;
        logic [DW-1:0] data;
    } req_t;

    // Reference model state (written only by the model process)
    req_t           exp_req_q[$];
    logic [1:0]     m_error = 2'd0;
    bit             m_busy = 1'b0;
    logic [AW-1:0]  m_addr = '0;
    logic [DW-1:0]  m_data = '0;
    logic [DRW-1:0] m_dr = '0;
    logic [DW-1:0]  mem[128];
    bit             dm_pend = 1'b0;

    // Debug-module behaviour knobs (written only by the main thread)
    int             ready_mode = 0;   // 0 always ready, 1 random, 2 never
    bit             resp_hold = 1'b0;
    bit             force_fail = 1'b0;
    int             fail_pct = 0;
    int             delay_max = 0;

    initial begin : model
        req_t           dm_req;
        int             dm_cnt;
        logic [1:0]     dm_code;
        logic [DW-1:0]  dm_rdata;
        bit             resp_acc;
        bit             stall;
        bit             cur_busy;
        logic [1:0]     cur_err;
        logic [1:0]     new_err;
        logic [DRW-1:0] exp_cap;
        logic [DRW-1:0] obs;
        int             scnt;
        dm_req = '0; dm_cnt = 0; dm_code = 2'd0; dm_rdata = '0;
        resp_acc = 1'b0; stall = 1'b0; exp_cap = '0; obs = '0; scnt = DRW;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[7'h11] = 32'h1234_5678;
        forever begin
            @(negedge tck);
            if (!trst_n) begin
                exp_req_q.delete();
                m_error = 2'd0; m_busy = 1'b0; m_addr = '0; m_data = '0; m_dr = '0;
                dm_pend = 1'b0; resp_acc = 1'b0; stall = 1'b0; scnt = DRW;
                dmi_resp_valid = 1'b0;
                continue;
            end
            cur_busy = m_busy;
            cur_err  = m_error;
            new_err  = m_error;
            if (resp_acc) begin
                dmi_resp_valid = 1'b0;
                resp_acc = 1'b0;
            end
            if (stall) check("req_valid_held", dmi_req_valid, 1);
            case (ready_mode)
                0:       dmi_req_ready = 1'b1;
                1:       dmi_req_ready = 1'($urandom_range(0, 1));
                default: dmi_req_ready = 1'b0;
            endcase
            stall = dmi_req_valid && !dmi_req_ready;
            // Request handshake on the coming edge
            if (dmi_req_valid && dmi_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr 0x%0h op %0d, none expected",
                             dmi_req_addr, dmi_req_op);
                end else begin
                    dm_req = exp_req_q.pop_front();
                    check("req_addr", dmi_req_addr, dm_req.addr);
                    check("req_op", dmi_req_op, dm_req.op);
                    if (dm_req.op == 2'd2) check("req_data", dmi_req_data, dm_req.data);
                    dm_pend = 1'b1;
                    dm_cnt = $urandom_range(0, delay_max);
                end
            end
            if (dm_pend && !dmi_resp_valid && !resp_hold) begin
                if (dm_cnt == 0) begin
                    if (force_fail) dm_code = 2'd2;
                    else if ($urandom_range(0, 99) < fail_pct) dm_code = 2'($urandom_range(1, 3));
                    else dm_code = 2'd0;
                    dm_rdata = (dm_req.op == 2'd1) ? mem[dm_req.addr] : $urandom;
                    dmi_resp = dm_code;
                    dmi_resp_data = dm_rdata;
                    dmi_resp_valid = 1'b1;
                end else begin
                    dm_cnt--;
                end
            end
            // JTAG side, evaluated against the state before the coming edge
            if (dmi_access && capture_dr) begin
                exp_cap = {m_addr, m_data, (cur_busy ? 2'd3 : cur_err)};
                m_dr = exp_cap;
                scnt = 0;
                if (cur_busy && new_err == 2'd0) new_err = 2'd3;
            end else if (dmi_access && shift_dr) begin
                if (scnt < DRW) begin
                    obs[scnt] = tdo;
                    scnt++;
                    if (scnt == DRW) check("dr_scan_out", obs, exp_cap);
                end
                m_dr = {tdi, m_dr[DRW-1:1]};
            end else if (dmi_access && update_dr) begin
                if (cur_err == 2'd0 && (m_dr[1:0] == 2'd1 || m_dr[1:0] == 2'd2)) begin
                    if (!cur_busy) begin
                        m_busy = 1'b1;
                        m_addr = m_dr[DRW-1:DW+2];
                        m_data = m_dr[DW+1:2];
                        exp_req_q.push_back('{m_dr[DRW-1:DW+2], m_dr[1:0], m_dr[DW+1:2]});
                    end else if (new_err == 2'd0) begin
                        new_err = 2'd3;
                    end
                end
            end
            // Response accepted on the coming edge
            if (dmi_resp_valid && dmi_resp_ready) begin
                if (dm_code == 2'd0) begin
                    if (dm_req.op == 2'd1) m_data = dm_rdata;
                    else mem[dm_req.addr] = dm_req.data;
                end else if (new_err == 2'd0) begin
                    new_err = 2'd2;
                end
                m_busy = 1'b0;
                dm_pend = 1'b0;
                resp_acc = 1'b1;
            end
            if (tlr) begin
                m_dr = '0;
                new_err = 2'd0;
                scnt = DRW;
            end
            if (dmi_reset) new_err = 2'd0;
            m_error = new_err;
        end
    end

    // One full DR scan: Capture, 41 x Shift (LSB first), Update.
    task automatic scan(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] op,
                        input bit acc);
        logic [DRW-1:0] vin;
        vin = {a, d, op};
        @(posedge tck); #1;
        dmi_access = acc; capture_dr = 1'b1;
        for (int i = 0; i < DRW; i++) begin
            @(posedge tck); #1;
            capture_dr = 1'b0; shift_dr = 1'b1; tdi = vin[i];
        end
        @(posedge tck); #1;
        shift_dr = 1'b0; update_dr = 1'b1;
        @(posedge tck); #1;
        update_dr = 1'b0; dmi_access = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (m_busy && c < 200) begin
            @(posedge tck);
            c++;
        end
        check("idle_timeout", m_busy, 0);
        @(posedge tck); #1;
    endtask

    task automatic wait_pend();
        int c;
        c = 0;
        while (!dm_pend && c < 200) begin
            @(posedge tck);
            c++;
        end
        check("req_issue_timeout", dm_pend, 1);
    endtask

    task automatic pulse_dmi_reset();
        @(posedge tck); #1;
        dmi_reset = 1'b1;
        @(posedge tck); #1;
        dmi_reset = 1'b0;
        check("err_after_dmireset", dmi_error, 0);
    endtask

    initial begin : stim
        #1 trst_n = 1'b0;
        #2;
        check("rst_tdo", tdo, 0);
        check("rst_error", dmi_error, 0);
        check("rst_req_valid", dmi_req_valid, 0);
        check("rst_resp_ready", dmi_resp_ready, 0);
        check("rst_req_fields", {dmi_req_addr, dmi_req_op, dmi_req_data}, 0);
        repeat (2) @(posedge tck);
        #1 trst_n = 1'b1;

        // Write with ready tied high and an immediate good response
        ready_mode = 0; delay_max = 0; fail_pct = 0;
        scan(7'h10, 32'hDEAD_BEEF, 2'd2, 1'b1);
        wait_idle();
        check("wr_error", dmi_error, 0);
        check("wr_idle", {dmi_req_valid, dmi_resp_ready}, 0);

        // Read, then a scan shows the returned data with op field 0
        scan(7'h11, 32'h0, 2'd1, 1'b1);
        wait_idle();
        scan(7'h0, 32'h0, 2'd0, 1'b1);

        // Second read while the first is held in WaitRead
        resp_hold = 1'b1;
        scan(7'h11, 32'h0, 2'd1, 1'b1);
        wait_pend();
        scan(7'h22, 32'h0, 2'd1, 1'b1);
        check("busy_no_second_req", exp_req_q.size(), 0);
        check("busy_error", dmi_error, 3);
        resp_hold = 1'b0;
        wait_idle();
        scan(7'h0, 32'h0, 2'd0, 1'b1);

        // Sticky busy blocks a write until dmireset
        scan(7'h30, 32'hCAFE_F00D, 2'd2, 1'b1);
        repeat (3) @(posedge tck);
        #1 check("blocked_no_req", dmi_req_valid, 0);
        pulse_dmi_reset();
        scan(7'h30, 32'hCAFE_F00D, 2'd2, 1'b1);
        wait_idle();
        check("write_after_clear_err", dmi_error, 0);

        // Failed read keeps the latched data and flags error 2
        force_fail = 1'b1;
        scan(7'h11, 32'h55AA_55AA, 2'd1, 1'b1);
        wait_idle();
        check("fail_error", dmi_error, 2);
        scan(7'h0, 32'h0, 2'd1, 1'b1);
        wait_idle();

        // Test-Logic-Reset clears the DR and the sticky error
        @(posedge tck); #1 tlr = 1'b1;
        @(posedge tck); #1 tlr = 1'b0;
        check("tlr_error", dmi_error, 0);
        check("tlr_tdo", tdo, 0);

        // Failing response and dmireset on the same edge
        resp_hold = 1'b1;
        scan(7'h12, 32'h0, 2'd1, 1'b1);
        wait_pend();
        @(posedge tck); #1;
        resp_hold = 1'b0; dmi_reset = 1'b1;
        @(posedge tck); #1;
        dmi_reset = 1'b0;
        check("fail_vs_dmireset", dmi_error, 0);
        check("fail_vs_dmireset_idle", dmi_resp_ready, 0);
        force_fail = 1'b0;

        // DR actions ignored without DMIACCESS
        scan(7'h50, 32'h1111_2222, 2'd2, 1'b0);
        repeat (3) @(posedge tck);
        #1 check("no_access_no_req", dmi_req_valid, 0);

        // Randomised traffic
        ready_mode = 1; delay_max = 3; fail_pct = 20;
        for (int n = 0; n < 40; n++) begin
            if (m_error != 2'd0 && $urandom_range(0, 1) == 1) pulse_dmi_reset();
            scan(7'($urandom), $urandom, 2'($urandom_range(0, 3)), 1'b1);
            wait_idle();
            check("rand_error", dmi_error, m_error);
        end
        scan(7'h0, 32'h0, 2'd0, 1'b1);
        if (m_error != 2'd0) pulse_dmi_reset();

        // trst mid-request aborts at once
        ready_mode = 2;
        scan(7'h40, 32'h0BAD_F00D, 2'd2, 1'b1);
        check("pre_trst_valid", dmi_req_valid, 1);
        #2 trst_n = 1'b0;
        #1;
        check("trst_req_valid", dmi_req_valid, 0);
        check("trst_resp_ready", dmi_resp_ready, 0);
        check("trst_error_tdo", {dmi_error, tdo}, 0);
        check("trst_req_fields", {dmi_req_addr, dmi_req_op, dmi_req_data}, 0);
        repeat (2) @(posedge tck);
        #1 trst_n = 1'b1;
        ready_mode = 1;
        scan(7'h0, 32'h0, 2'd0, 1'b1);

        repeat (3) @(posedge tck);
        check("leftover_req", exp_req_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
